// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: default widths, the default
// access timeout, and the state encoding of the data-memory request FSM.
package riscv_mem_pkg;

   localparam int unsigned XLEN_DEF           = 32;
   localparam int unsigned REG_ADDR_W_DEF     = 5;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP
   } mem_state_t;

endpackage

// File: rtl/memory_stage_dmem_req_fsm.sv
// Data-memory request sequencer for the memory stage.
// Owns the request state, the access timeout counter, the request drive
// and the completion / fault / stall indications for the op currently held
// in the EX/MEM register.
//   mem_op, is_load, misaligned : decoded view of the held op
//   op_addr, op_wdata           : address / store data of the held op
//   dmem_req_*                  : valid/ready request channel
//   dmem_rsp_valid              : read response strobe
//   complete, fault, stall      : op retires this cycle / retires faulted /
//                                 op still in flight
module dmem_req_fsm
   import riscv_mem_pkg::*;
#(
   parameter int unsigned XLEN           = XLEN_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_op,
   input  logic            is_load,
   input  logic            misaligned,
   input  logic [XLEN-1:0] op_addr,
   input  logic [XLEN-1:0] op_wdata,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_req_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_rsp_valid,
   output logic            complete,
   output logic            fault,
   output logic            stall
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Address and data come straight from the held EX/MEM register, which
   // is frozen while stalled, so they stay stable until acceptance.
   assign dmem_req_we = ~is_load;
   assign dmem_addr   = op_addr;
   assign dmem_wdata  = op_wdata;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      dmem_req_valid = 1'b0;
      complete       = 1'b0;
      fault          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (misaligned) begin
                  complete = 1'b1;
                  fault    = 1'b1;
               end else begin
                  dmem_req_valid = 1'b1;
                  cnt_d          = '0;
                  if (dmem_req_ready) begin
                     if (is_load) state_d = WAIT_RSP;
                     else         complete = 1'b1;
                  end else begin
                     state_d = REQ;
                  end
               end
            end
         end
         REQ: begin
            dmem_req_valid = 1'b1;
            // Acceptance wins over a timeout landing in the same cycle.
            if (dmem_req_ready) begin
               cnt_d = '0;
               if (is_load) begin
                  state_d = WAIT_RSP;
               end else begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               complete = 1'b1;
               fault    = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_RSP: begin
            if (dmem_rsp_valid) begin
               complete = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               complete = 1'b1;
               fault    = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall = mem_op & ~complete;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage, downstream of execute.
// Holds the EX/MEM register, sequences word loads/stores over the
// valid/ready data-memory port through dmem_req_fsm, and produces the
// MEM/WB register for write-back.
//   *_e inputs        : instruction from execute (valid_e, flush_e qualify)
//   execute_out_m     : registered execute result, forwarded to execute
//   stall_m           : freezes fetch/decode/execute while an access is open
//   dmem_*            : data-memory request / response channel
//   reg_*_w           : write-back register outputs
//   mem_fault_w       : one-cycle pulse for a misaligned or timed-out op
module memory_stage
   import riscv_mem_pkg::*;
#(
   parameter int unsigned XLEN           = XLEN_DEF,
   parameter int unsigned REG_ADDR_W     = REG_ADDR_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [XLEN-1:0]       execute_out_e,
   input  logic [XLEN-1:0]       reg_readdata2_e,
   input  logic [REG_ADDR_W-1:0] reg_write_addr_e,
   input  logic                  reg_write_en_e,
   input  logic                  dmem_read_en_e,
   input  logic                  dmem_write_en_e,
   input  logic                  reg_writedata_sel_e,
   input  logic                  valid_e,
   input  logic                  flush_e,
   output logic [XLEN-1:0]       execute_out_m,
   output logic                  stall_m,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_req_we,
   output logic [XLEN-1:0]       dmem_addr,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [XLEN-1:0]       dmem_rsp_rdata,
   output logic [XLEN-1:0]       reg_writedata_w,
   output logic [REG_ADDR_W-1:0] reg_write_addr_w,
   output logic                  reg_write_en_w,
   output logic                  mem_fault_w
);

   // EX/MEM register
   logic                  valid_q,  valid_d;
   logic [XLEN-1:0]       exout_q,  exout_d;
   logic [XLEN-1:0]       wdata_q,  wdata_d;
   logic [REG_ADDR_W-1:0] rd_q,     rd_d;
   logic                  rwe_q,    rwe_d;
   logic                  rden_q,   rden_d;
   logic                  wren_q,   wren_d;
   logic                  sel_q,    sel_d;

   // MEM/WB register
   logic [XLEN-1:0]       wb_data_q,  wb_data_d;
   logic [REG_ADDR_W-1:0] wb_addr_q,  wb_addr_d;
   logic                  wb_we_q,    wb_we_d;
   logic                  wb_fault_q, wb_fault_d;

   logic mem_op, is_load, is_store, misaligned;
   logic op_complete, op_fault;

   assign mem_op     = valid_q & (rden_q | wren_q);
   assign is_load    = rden_q;
   assign is_store   = wren_q & ~rden_q;
   assign misaligned = |exout_q[1:0];

   dmem_req_fsm #(
      .XLEN           (XLEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_req_fsm (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_op         (mem_op),
      .is_load        (is_load),
      .misaligned     (misaligned),
      .op_addr        (exout_q),
      .op_wdata       (wdata_q),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_req_we    (dmem_req_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .complete       (op_complete),
      .fault          (op_fault),
      .stall          (stall_m)
   );

   always_comb begin
      valid_d = valid_q;
      exout_d = exout_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      rwe_d   = rwe_q;
      rden_d  = rden_q;
      wren_d  = wren_q;
      sel_d   = sel_q;
      if (!stall_m) begin
         valid_d = valid_e & ~flush_e;
         exout_d = execute_out_e;
         wdata_d = reg_readdata2_e;
         rd_d    = reg_write_addr_e;
         rwe_d   = reg_write_en_e;
         rden_d  = dmem_read_en_e;
         wren_d  = dmem_write_en_e;
         sel_d   = reg_writedata_sel_e;
      end
   end

   always_comb begin
      wb_data_d  = wb_data_q;
      wb_addr_d  = wb_addr_q;
      wb_we_d    = 1'b0;
      wb_fault_d = 1'b0;
      if (!stall_m) begin
         wb_we_d    = valid_q & rwe_q & ~is_store & ~op_fault;
         wb_addr_d  = rd_q;
         wb_data_d  = sel_q ? dmem_rsp_rdata : exout_q;
         wb_fault_d = op_fault;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         exout_q    <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         rwe_q      <= 1'b0;
         rden_q     <= 1'b0;
         wren_q     <= 1'b0;
         sel_q      <= 1'b0;
         wb_data_q  <= '0;
         wb_addr_q  <= '0;
         wb_we_q    <= 1'b0;
         wb_fault_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         exout_q    <= exout_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         rwe_q      <= rwe_d;
         rden_q     <= rden_d;
         wren_q     <= wren_d;
         sel_q      <= sel_d;
         wb_data_q  <= wb_data_d;
         wb_addr_q  <= wb_addr_d;
         wb_we_q    <= wb_we_d;
         wb_fault_q <= wb_fault_d;
      end
   end

   assign execute_out_m    = exout_q;
   assign reg_writedata_w  = wb_data_q;
   assign reg_write_addr_w = wb_addr_q;
   assign reg_write_en_w   = wb_we_q;
   assign mem_fault_w      = wb_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage (TIMEOUT_CYCLES = 4). Stimulus pushes
// expected write-back events and expected accepted requests into queues;
// monitors pop and compare whenever the DUT presents them.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] execute_out_e, reg_readdata2_e;
   logic [4:0]  reg_write_addr_e;
   logic        reg_write_en_e, dmem_read_en_e, dmem_write_en_e;
   logic        reg_writedata_sel_e, valid_e, flush_e;
   logic [31:0] execute_out_m;
   logic        stall_m;
   logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic [31:0] reg_writedata_w;
   logic [4:0]  reg_write_addr_w;
   logic        reg_write_en_w, mem_fault_w;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic        fault;
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   wb_t  wb_q[$];
   req_t req_q[$];

   memory_stage #(
      .XLEN           (32),
      .REG_ADDR_W     (5),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .execute_out_e       (execute_out_e),
      .reg_readdata2_e     (reg_readdata2_e),
      .reg_write_addr_e    (reg_write_addr_e),
      .reg_write_en_e      (reg_write_en_e),
      .dmem_read_en_e      (dmem_read_en_e),
      .dmem_write_en_e     (dmem_write_en_e),
      .reg_writedata_sel_e (reg_writedata_sel_e),
      .valid_e             (valid_e),
      .flush_e             (flush_e),
      .execute_out_m       (execute_out_m),
      .stall_m             (stall_m),
      .dmem_req_valid      (dmem_req_valid),
      .dmem_req_ready      (dmem_req_ready),
      .dmem_req_we         (dmem_req_we),
      .dmem_addr           (dmem_addr),
      .dmem_wdata          (dmem_wdata),
      .dmem_rsp_valid      (dmem_rsp_valid),
      .dmem_rsp_rdata      (dmem_rsp_rdata),
      .reg_writedata_w     (reg_writedata_w),
      .reg_write_addr_w    (reg_write_addr_w),
      .reg_write_en_w      (reg_write_en_w),
      .mem_fault_w         (mem_fault_w)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write-back monitor
   always @(negedge clk) begin
      if (rst_n && (reg_write_en_w || mem_fault_w)) begin
         if (wb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got we=%b fault=%b rd=%0d expected no event",
                     reg_write_en_w, mem_fault_w, reg_write_addr_w);
         end else begin
            wb_t e;
            e = wb_q.pop_front();
            chk("wb_we", {31'b0, reg_write_en_w}, {31'b0, e.we});
            chk("wb_fault", {31'b0, mem_fault_w}, {31'b0, e.fault});
            if (e.we) begin
               chk("wb_addr", {27'b0, reg_write_addr_w}, {27'b0, e.addr});
               chk("wb_data", reg_writedata_w, e.data);
            end
         end
      end
   end

   // Request-acceptance monitor
   always @(negedge clk) begin
      if (rst_n && dmem_req_valid && dmem_req_ready) begin
         if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got addr=%h we=%b expected no request",
                     dmem_addr, dmem_req_we);
         end else begin
            req_t r;
            r = req_q.pop_front();
            chk("req_we", {31'b0, dmem_req_we}, {31'b0, r.we});
            chk("req_addr", dmem_addr, r.addr);
            if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rwe, input logic rden, input logic wren, input logic sel);
      valid_e             = 1'b1;
      flush_e             = 1'b0;
      execute_out_e       = addr;
      reg_readdata2_e     = wd;
      reg_write_addr_e    = rd;
      reg_write_en_e      = rwe;
      dmem_read_en_e      = rden;
      dmem_write_en_e     = wren;
      reg_writedata_sel_e = sel;
   endtask

   task automatic bubble();
      valid_e             = 1'b0;
      flush_e             = 1'b0;
      execute_out_e       = 32'h0;
      reg_readdata2_e     = 32'h0;
      reg_write_addr_e    = 5'd0;
      reg_write_en_e      = 1'b0;
      dmem_read_en_e      = 1'b0;
      dmem_write_en_e     = 1'b0;
      reg_writedata_sel_e = 1'b0;
   endtask

   task automatic push_wb(input logic we, input logic fault, input logic [4:0] a, input logic [31:0] d);
      wb_t e;
      e.we = we; e.fault = fault; e.addr = a; e.data = d;
      wb_q.push_back(e);
   endtask

   task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      req_q.push_back(r);
   endtask

   initial begin
      rst_n          = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = 32'h0;
      bubble();
      #2;
      chk("rst_stall", {31'b0, stall_m}, 32'd0);
      chk("rst_req_valid", {31'b0, dmem_req_valid}, 32'd0);
      chk("rst_exout", execute_out_m, 32'd0);
      chk("rst_wb_en", {31'b0, reg_write_en_w}, 32'd0);
      chk("rst_fault", {31'b0, mem_fault_w}, 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;

      // ALU op
      cyc();
      drive(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      push_wb(1'b1, 1'b0, 5'd5, 32'h10);
      cyc();
      bubble();
      @(negedge clk);
      chk("alu_exout", execute_out_m, 32'h10);
      chk("alu_stall0", {31'b0, stall_m}, 32'd0);
      cyc();
      @(negedge clk);
      chk("alu_stall1", {31'b0, stall_m}, 32'd0);

      // Store, ready low for 3 cycles; reg_write_en_e set but must not write back
      cyc();
      drive(32'h100, 32'hDEAD_BEEF, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      push_req(1'b1, 32'h100, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
         cyc();
         bubble();
         dmem_req_ready = (i == 3);
         @(negedge clk);
         chk("st_req_valid", {31'b0, dmem_req_valid}, 32'd1);
         chk("st_addr", dmem_addr, 32'h100);
         chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
         chk("st_stall", {31'b0, stall_m}, (i < 3) ? 32'd1 : 32'd0);
      end
      cyc();
      dmem_req_ready = 1'b0;
      @(negedge clk);
      chk("st_req_drop", {31'b0, dmem_req_valid}, 32'd0);
      chk("st_no_wb", {31'b0, reg_write_en_w}, 32'd0);

      // Load, response two cycles after acceptance
      cyc();
      drive(32'h200, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      dmem_req_ready = 1'b1;
      push_req(1'b0, 32'h200, 32'h0);
      push_wb(1'b1, 1'b0, 5'd7, 32'h1234_5678);
      cyc();
      bubble();
      @(negedge clk);
      chk("ld_stall_a0", {31'b0, stall_m}, 32'd1);
      cyc();
      dmem_req_ready = 1'b0;
      @(negedge clk);
      chk("ld_stall_a1", {31'b0, stall_m}, 32'd1);
      chk("ld_bubble_a1", {31'b0, reg_write_en_w}, 32'd0);
      cyc();
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("ld_stall_a2", {31'b0, stall_m}, 32'd0);
      chk("ld_bubble_a2", {31'b0, reg_write_en_w}, 32'd0);
      cyc();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = 32'h0;
      @(negedge clk);

      // Misaligned load
      cyc();
      drive(32'h203, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      dmem_req_ready = 1'b1;
      push_wb(1'b0, 1'b1, 5'd3, 32'h0);
      cyc();
      bubble();
      @(negedge clk);
      chk("mis_req_valid", {31'b0, dmem_req_valid}, 32'd0);
      chk("mis_stall", {31'b0, stall_m}, 32'd0);
      cyc();
      dmem_req_ready = 1'b0;
      @(negedge clk);
      cyc();
      @(negedge clk);

      // Store never accepted: times out in REQ
      cyc();
      drive(32'h180, 32'h0000_55AA, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      push_wb(1'b0, 1'b1, 5'd4, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         bubble();
         @(negedge clk);
         chk("sto_stall", {31'b0, stall_m}, (i < 4) ? 32'd1 : 32'd0);
      end
      cyc();
      @(negedge clk);
      chk("sto_req_drop", {31'b0, dmem_req_valid}, 32'd0);

      // Load accepted, no response: times out in WAIT_RSP, late response ignored
      cyc();
      drive(32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
      dmem_req_ready = 1'b1;
      push_req(1'b0, 32'h300, 32'h0);
      push_wb(1'b0, 1'b1, 5'd9, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         bubble();
         if (i == 1) dmem_req_ready = 1'b0;
         @(negedge clk);
         chk("lto_stall", {31'b0, stall_m}, (i < 4) ? 32'd1 : 32'd0);
      end
      cyc();
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("lto_late_req", {31'b0, dmem_req_valid}, 32'd0);
      chk("lto_late_stall", {31'b0, stall_m}, 32'd0);
      cyc();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = 32'h0;
      @(negedge clk);
      chk("lto_late_wb", {31'b0, reg_write_en_w}, 32'd0);

      // Reset while waiting for a response
      cyc();
      drive(32'h400, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
      dmem_req_ready = 1'b1;
      push_req(1'b0, 32'h400, 32'h0);
      cyc();
      bubble();
      @(negedge clk);
      cyc();
      dmem_req_ready = 1'b0;
      @(negedge clk);
      chk("rw_stall_pre", {31'b0, stall_m}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rw_req_valid", {31'b0, dmem_req_valid}, 32'd0);
      chk("rw_stall", {31'b0, stall_m}, 32'd0);
      chk("rw_exout", execute_out_m, 32'd0);
      chk("rw_wb_data", reg_writedata_w, 32'd0);
      chk("rw_wb_en", {31'b0, reg_write_en_w}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // Load after reset, response the cycle after acceptance
      cyc();
      drive(32'h500, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
      dmem_req_ready = 1'b1;
      push_req(1'b0, 32'h500, 32'h0);
      push_wb(1'b1, 1'b0, 5'd11, 32'hCAFE_F00D);
      cyc();
      bubble();
      @(negedge clk);
      chk("rl_stall_a0", {31'b0, stall_m}, 32'd1);
      cyc();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rl_stall_a1", {31'b0, stall_m}, 32'd0);
      cyc();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = 32'h0;

      // Drain with a bounded wait
      for (int i = 0; i < 20; i++) begin
         if (wb_q.size() == 0 && req_q.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      chk("wb_queue_empty", wb_q.size(), 32'd0);
      chk("req_queue_empty", req_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
